// File: rtl/gpr_sb_regfile_pkg.sv
// ---------------------------------------------------------------------------
// gpr_sb_regfile_pkg
// Shared constants for the integer register file slice.
//   XLEN_DEF / NREG_DEF : default data width and register count
//   REG_ZERO / REG_A0   : architectural indices of x0 and a0
//   GPR_NREG_SEL(e)     : register count for RV32E (e=1) or RV32I (e=0)
// ---------------------------------------------------------------------------
`ifndef GPR_SB_REGFILE_PKG_SV
`define GPR_SB_REGFILE_PKG_SV

`define GPR_NREG_SEL(is_rv32e) ((is_rv32e) ? 16 : 32)

package gpr_sb_regfile_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = `GPR_NREG_SEL(0);
  localparam int REG_ZERO = 0;
  localparam int REG_A0   = 10;
endpackage

`endif

// File: rtl/gpr_sb_regfile_if.sv
// ---------------------------------------------------------------------------
// gpr_sb_regfile_if
// Bundle of the read, write-back, issue and status signals of the register
// file. The master side is decode/issue plus the two write-back stages; the
// slave side is the register file itself.
//   raddr1/2, rdata1/2, rrdy1/2 : two read ports with operand-ready flags
//   wen0/waddr0/wdata0          : write port 0 (EXU)
//   wen1/waddr1/wdata1          : write port 1 (LSU)
//   iss_en/iss_rd               : destination of the issued instruction
//   busy_vec, dbg_a0            : scoreboard state and a0 for the harness
// ---------------------------------------------------------------------------
interface gpr_sb_regfile_if
  import gpr_sb_regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF
);
  localparam int AW = $clog2(NREG);

  logic [AW-1:0]   raddr1;
  logic [AW-1:0]   raddr2;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic            rrdy1;
  logic            rrdy2;
  logic            wen0;
  logic [AW-1:0]   waddr0;
  logic [XLEN-1:0] wdata0;
  logic            wen1;
  logic [AW-1:0]   waddr1;
  logic [XLEN-1:0] wdata1;
  logic            iss_en;
  logic [AW-1:0]   iss_rd;
  logic [NREG-1:0] busy_vec;
  logic [XLEN-1:0] dbg_a0;

  modport master (
    output raddr1, raddr2, wen0, waddr0, wdata0, wen1, waddr1, wdata1,
           iss_en, iss_rd,
    input  rdata1, rdata2, rrdy1, rrdy2, busy_vec, dbg_a0
  );

  modport slave (
    input  raddr1, raddr2, wen0, waddr0, wdata0, wen1, waddr1, wdata1,
           iss_en, iss_rd,
    output rdata1, rdata2, rrdy1, rrdy2, busy_vec, dbg_a0
  );
endinterface

// File: rtl/gpr_sb_regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// gpr_scoreboard
// Per-register busy bits. An issue marks its destination busy, a write-back
// clears it; a set wins over a clear on the same register because the newly
// issued producer now owns it. x0 is never busy.
//   clk, rst              : clock, synchronous active-high reset
//   wen0/waddr0, wen1/... : write-back ports (already qualified by the top)
//   iss_en, iss_rd        : issue destination
//   raddr1, raddr2        : read addresses whose readiness is reported
//   rrdy1, rrdy2          : operand ready (not busy, x0, or bypassed)
//   busy_vec              : current busy bits
// ---------------------------------------------------------------------------
module gpr_scoreboard
  import gpr_sb_regfile_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wen0_i,
  input  logic [AW-1:0]   waddr0_i,
  input  logic            wen1_i,
  input  logic [AW-1:0]   waddr1_i,
  input  logic            iss_en_i,
  input  logic [AW-1:0]   iss_rd_i,
  input  logic [AW-1:0]   raddr1_i,
  input  logic [AW-1:0]   raddr2_i,
  output logic            rrdy1_o,
  output logic            rrdy2_o,
  output logic [NREG-1:0] busy_vec_o
);
  localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);
  localparam bit            BYP      = (BYPASS != 0);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  assign busy_d[0] = 1'b0;

  for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
    localparam logic [AW-1:0] IDX = AW'(gi);
    logic set_hit;
    logic clr_hit;
    assign set_hit    = iss_en_i && (iss_rd_i == IDX);
    assign clr_hit    = (wen0_i && (waddr0_i == IDX)) || (wen1_i && (waddr1_i == IDX));
    assign busy_d[gi] = set_hit | (busy_q[gi] & ~clr_hit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // A write landing this cycle makes the operand available through the
  // bypass, so it counts as ready even though busy is still set.
  for (genvar gi = 0; gi < 2; gi++) begin : g_rdy
    logic [AW-1:0] addr;
    logic          wr_hit;
    logic          rdy;
    assign addr   = (gi == 0) ? raddr1_i : raddr2_i;
    assign wr_hit = (wen0_i && (waddr0_i == addr)) || (wen1_i && (waddr1_i == addr));
    assign rdy    = (addr == ZERO_IDX) | ~busy_q[addr] | (BYP & wr_hit);
  end

  assign rrdy1_o    = g_rdy[0].rdy;
  assign rrdy2_o    = g_rdy[1].rdy;
  assign busy_vec_o = busy_q;
endmodule

// File: rtl/gpr_sb_regfile.sv
// ---------------------------------------------------------------------------
// gpr_sb_regfile
// Integer register file with two write-back ports (EXU on port 0, LSU on
// port 1), two combinational read ports with optional same-cycle bypass,
// and a busy scoreboard used by issue to stall.
//   clk, rst : clock, synchronous active-high reset
//   bus      : gpr_sb_regfile_if slave (read/write/issue/status signals)
// Parameters XLEN and NREG must match those of the connected interface.
// ---------------------------------------------------------------------------
module gpr_sb_regfile
  import gpr_sb_regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int BYPASS = 1
) (
  input logic             clk,
  input logic             rst,
  gpr_sb_regfile_if.slave bus
);
  localparam int            AW       = $clog2(NREG);
  localparam logic [AW-1:0] ZERO_IDX = AW'(REG_ZERO);
  localparam logic [AW-1:0] A0_IDX   = AW'(REG_A0);
  localparam bit            BYP      = (BYPASS != 0);

  // Entry 0 exists only to keep indexing simple; it is never written and
  // reads of x0 are forced to zero below.
  logic [XLEN-1:0] regs_q [NREG];

  // Write-backs have no effect while reset is asserted, including on the
  // bypass path and on the ready flags.
  logic wr0_v;
  logic wr1_v;
  assign wr0_v = bus.wen0 & ~rst;
  assign wr1_v = bus.wen1 & ~rst;

  // Port 1 is assigned last so it wins when both ports hit one register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (bus.wen0 && (bus.waddr0 != ZERO_IDX)) begin
        regs_q[bus.waddr0] <= bus.wdata0;
      end
      if (bus.wen1 && (bus.waddr1 != ZERO_IDX)) begin
        regs_q[bus.waddr1] <= bus.wdata1;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [AW-1:0]   raddr;
    logic [XLEN-1:0] rdata;
    assign raddr = (gi == 0) ? bus.raddr1 : bus.raddr2;
    always_comb begin
      rdata = regs_q[raddr];
      if (raddr == ZERO_IDX) begin
        rdata = '0;
      end else if (BYP && wr1_v && (bus.waddr1 == raddr)) begin
        rdata = bus.wdata1;
      end else if (BYP && wr0_v && (bus.waddr0 == raddr)) begin
        rdata = bus.wdata0;
      end
    end
  end

  assign bus.rdata1 = g_rd[0].rdata;
  assign bus.rdata2 = g_rd[1].rdata;
  assign bus.dbg_a0 = regs_q[A0_IDX];

  gpr_scoreboard #(
    .NREG   (NREG),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .wen0_i     (wr0_v),
    .waddr0_i   (bus.waddr0),
    .wen1_i     (wr1_v),
    .waddr1_i   (bus.waddr1),
    .iss_en_i   (bus.iss_en),
    .iss_rd_i   (bus.iss_rd),
    .raddr1_i   (bus.raddr1),
    .raddr2_i   (bus.raddr2),
    .rrdy1_o    (bus.rrdy1),
    .rrdy2_o    (bus.rrdy2),
    .busy_vec_o (bus.busy_vec)
  );
endmodule

// File: tb/tb_gpr_sb_regfile.sv
// ---------------------------------------------------------------------------
// tb_gpr_sb_regfile
// Drives two builds side by side: dut 0 = NREG 32 with bypass, dut 1 =
// NREG 16 without bypass. Directed steps first, then random traffic against
// an array-based reference of the architectural state.
// ---------------------------------------------------------------------------
module tb_gpr_sb_regfile;
  typedef struct packed {
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic        wen0;
    logic [4:0]  waddr0;
    logic [31:0] wdata0;
    logic        wen1;
    logic [4:0]  waddr1;
    logic [31:0] wdata1;
    logic        iss_en;
    logic [4:0]  iss_rd;
  } stim_t;

  logic  clk;
  logic  rst_a;
  logic  rst_b;
  stim_t st [2];

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [31:0] mreg  [2][32];
  bit          mbusy [2][32];
  int          nreg_of [2] = '{32, 16};
  bit          byp_of  [2] = '{1'b1, 1'b0};

  gpr_sb_regfile_if #(.XLEN(32), .NREG(32)) ifa ();
  gpr_sb_regfile_if #(.XLEN(32), .NREG(16)) ifb ();

  gpr_sb_regfile #(.XLEN(32), .NREG(32), .BYPASS(1)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (ifa)
  );

  gpr_sb_regfile #(.XLEN(32), .NREG(16), .BYPASS(0)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ifb)
  );

  assign ifa.raddr1 = st[0].raddr1;
  assign ifa.raddr2 = st[0].raddr2;
  assign ifa.wen0   = st[0].wen0;
  assign ifa.waddr0 = st[0].waddr0;
  assign ifa.wdata0 = st[0].wdata0;
  assign ifa.wen1   = st[0].wen1;
  assign ifa.waddr1 = st[0].waddr1;
  assign ifa.wdata1 = st[0].wdata1;
  assign ifa.iss_en = st[0].iss_en;
  assign ifa.iss_rd = st[0].iss_rd;

  assign ifb.raddr1 = st[1].raddr1[3:0];
  assign ifb.raddr2 = st[1].raddr2[3:0];
  assign ifb.wen0   = st[1].wen0;
  assign ifb.waddr0 = st[1].waddr0[3:0];
  assign ifb.wdata0 = st[1].wdata0;
  assign ifb.wen1   = st[1].wen1;
  assign ifb.waddr1 = st[1].waddr1[3:0];
  assign ifb.wdata1 = st[1].wdata1;
  assign ifb.iss_en = st[1].iss_en;
  assign ifb.iss_rd = st[1].iss_rd[3:0];

  logic [31:0] o_rdata1 [2];
  logic [31:0] o_rdata2 [2];
  logic        o_rrdy1  [2];
  logic        o_rrdy2  [2];
  logic [31:0] o_busy   [2];
  logic [31:0] o_dbg    [2];

  assign o_rdata1[0] = ifa.rdata1;
  assign o_rdata2[0] = ifa.rdata2;
  assign o_rrdy1[0]  = ifa.rrdy1;
  assign o_rrdy2[0]  = ifa.rrdy2;
  assign o_busy[0]   = ifa.busy_vec;
  assign o_dbg[0]    = ifa.dbg_a0;
  assign o_rdata1[1] = ifb.rdata1;
  assign o_rdata2[1] = ifb.rdata2;
  assign o_rrdy1[1]  = ifb.rrdy1;
  assign o_rrdy2[1]  = ifb.rrdy2;
  assign o_busy[1]   = {16'h0000, ifb.busy_vec};
  assign o_dbg[1]    = ifb.dbg_a0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit rst_of(int d);
    return (d == 0) ? rst_a : rst_b;
  endfunction

  function automatic bit wr_hit(int d, logic [4:0] a, output logic [31:0] val);
    val = 32'h0;
    if (!byp_of[d] || rst_of(d)) return 1'b0;
    if (st[d].wen1 && st[d].waddr1 == a) begin
      val = st[d].wdata1;
      return 1'b1;
    end
    if (st[d].wen0 && st[d].waddr0 == a) begin
      val = st[d].wdata0;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_rdata(int d, logic [4:0] a);
    logic [31:0] v;
    if (a == 0) return 32'h0;
    if (wr_hit(d, a, v)) return v;
    return mreg[d][a];
  endfunction

  function automatic logic [31:0] exp_rrdy(int d, logic [4:0] a);
    logic [31:0] v;
    if (a == 0) return 32'd1;
    if (!mbusy[d][a]) return 32'd1;
    if (wr_hit(d, a, v)) return 32'd1;
    return 32'd0;
  endfunction

  function automatic logic [31:0] exp_busy(int d);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < nreg_of[d]; i++) v[i] = mbusy[d][i];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(int d);
    if (rst_of(d)) begin
      for (int i = 0; i < 32; i++) begin
        mreg[d][i]  = 32'h0;
        mbusy[d][i] = 1'b0;
      end
    end else begin
      if (st[d].wen0 && st[d].waddr0 != 0) mreg[d][st[d].waddr0] = st[d].wdata0;
      if (st[d].wen1 && st[d].waddr1 != 0) mreg[d][st[d].waddr1] = st[d].wdata1;
      if (st[d].wen0 && st[d].waddr0 != 0) mbusy[d][st[d].waddr0] = 1'b0;
      if (st[d].wen1 && st[d].waddr1 != 0) mbusy[d][st[d].waddr1] = 1'b0;
      if (st[d].iss_en && st[d].iss_rd != 0) mbusy[d][st[d].iss_rd] = 1'b1;
    end
  endtask

  // Compare every output of both builds against the reference, then clock.
  task automatic tick();
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d rdata1 a=%0d", d, st[d].raddr1), o_rdata1[d], exp_rdata(d, st[d].raddr1));
      chk($sformatf("dut%0d rdata2 a=%0d", d, st[d].raddr2), o_rdata2[d], exp_rdata(d, st[d].raddr2));
      chk($sformatf("dut%0d rrdy1", d), {31'b0, o_rrdy1[d]}, exp_rrdy(d, st[d].raddr1));
      chk($sformatf("dut%0d rrdy2", d), {31'b0, o_rrdy2[d]}, exp_rrdy(d, st[d].raddr2));
      chk($sformatf("dut%0d busy_vec", d), o_busy[d], exp_busy(d));
      chk($sformatf("dut%0d dbg_a0", d), o_dbg[d], mreg[d][10]);
    end
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
  endtask

  task automatic idle(int d);
    st[d] = '0;
  endtask

  task automatic rand_in(int d);
    int hi;
    hi = ($urandom_range(0, 1) == 1) ? 7 : nreg_of[d] - 1;
    st[d].raddr1 = 5'($urandom_range(0, hi));
    st[d].raddr2 = 5'($urandom_range(0, hi));
    st[d].wen0   = 1'($urandom_range(0, 1));
    st[d].waddr0 = 5'($urandom_range(0, hi));
    st[d].wdata0 = $urandom;
    st[d].wen1   = 1'($urandom_range(0, 1));
    st[d].waddr1 = 5'($urandom_range(0, hi));
    st[d].wdata1 = $urandom;
    st[d].iss_en = ($urandom_range(0, 9) < 4);
    st[d].iss_rd = 5'($urandom_range(0, hi));
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    idle(0);
    idle(1);
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Reset state read-back
    st[0].raddr1 = 5'd5;
    st[0].raddr2 = 5'd10;
    st[1].raddr1 = 5'd5;
    st[1].raddr2 = 5'd10;
    #1;
    chk("reset rdata1", o_rdata1[0], 32'h0);
    chk("reset rdata2", o_rdata2[0], 32'h0);
    chk("reset rrdy1", {31'b0, o_rrdy1[0]}, 32'd1);
    chk("reset rrdy2", {31'b0, o_rrdy2[0]}, 32'd1);
    chk("reset busy_vec", o_busy[0], 32'h0);
    chk("reset dbg_a0", o_dbg[0], 32'h0);
    chk("reset dbg_a0 nreg16", o_dbg[1], 32'h0);
    tick();

    // x0 is never written nor marked busy
    idle(0);
    st[0].wen0 = 1'b1; st[0].waddr0 = 5'd0; st[0].wdata0 = 32'hDEADBEEF;
    st[0].iss_en = 1'b1; st[0].iss_rd = 5'd0;
    #1;
    chk("x0 rdata1", o_rdata1[0], 32'h0);
    chk("x0 rrdy1", {31'b0, o_rrdy1[0]}, 32'd1);
    tick();
    idle(0);
    #1;
    chk("x0 busy_vec", o_busy[0], 32'h0);
    chk("x0 rdata after", o_rdata1[0], 32'h0);
    tick();

    // Both ports write reg 7: LSU wins, bypass included
    idle(0);
    st[0].wen0 = 1'b1; st[0].waddr0 = 5'd7; st[0].wdata0 = 32'h11;
    st[0].wen1 = 1'b1; st[0].waddr1 = 5'd7; st[0].wdata1 = 32'h22;
    st[0].raddr1 = 5'd7;
    #1;
    chk("dual bypass rdata1", o_rdata1[0], 32'h22);
    chk("dual bypass rrdy1", {31'b0, o_rrdy1[0]}, 32'd1);
    tick();
    idle(0);
    st[0].raddr1 = 5'd7;
    #1;
    chk("dual stored r7", o_rdata1[0], 32'h22);
    tick();

    // Scoreboard: issue, stall, write-back releases
    idle(0);
    st[0].iss_en = 1'b1; st[0].iss_rd = 5'd3;
    tick();
    idle(0);
    st[0].raddr1 = 5'd3;
    #1;
    chk("sb r3 not ready", {31'b0, o_rrdy1[0]}, 32'd0);
    chk("sb busy3 set", {31'b0, o_busy[0][3]}, 32'd1);
    tick();
    idle(0);
    st[0].raddr1 = 5'd3;
    st[0].wen1 = 1'b1; st[0].waddr1 = 5'd3; st[0].wdata1 = 32'h55;
    #1;
    chk("sb wb rrdy1", {31'b0, o_rrdy1[0]}, 32'd1);
    chk("sb wb rdata1", o_rdata1[0], 32'h55);
    tick();
    idle(0);
    st[0].raddr1 = 5'd3;
    #1;
    chk("sb busy3 cleared", {31'b0, o_busy[0][3]}, 32'd0);
    tick();

    // Set beats clear on the same register
    idle(0);
    st[0].iss_en = 1'b1; st[0].iss_rd = 5'd4;
    tick();
    idle(0);
    st[0].wen0 = 1'b1; st[0].waddr0 = 5'd4; st[0].wdata0 = 32'hCAFE0004;
    st[0].iss_en = 1'b1; st[0].iss_rd = 5'd4;
    tick();
    idle(0);
    st[0].raddr1 = 5'd4;
    #1;
    chk("collide busy4", {31'b0, o_busy[0][4]}, 32'd1);
    chk("collide r4 data", o_rdata1[0], 32'hCAFE0004);
    chk("collide r4 rrdy", {31'b0, o_rrdy1[0]}, 32'd0);
    tick();
    idle(0);
    st[0].wen1 = 1'b1; st[0].waddr1 = 5'd4; st[0].wdata1 = 32'h4;
    tick();
    idle(0);

    // NREG=16, no bypass
    st[1].wen0 = 1'b1; st[1].waddr0 = 5'd15; st[1].wdata0 = 32'hA5;
    st[1].raddr1 = 5'd15;
    #1;
    chk("nb r15 same cycle", o_rdata1[1], 32'h0);
    tick();
    idle(1);
    st[1].raddr1 = 5'd15;
    #1;
    chk("nb r15 next cycle", o_rdata1[1], 32'hA5);
    tick();
    idle(1);
    st[1].wen1 = 1'b1; st[1].waddr1 = 5'd10; st[1].wdata1 = 32'h12345678;
    #1;
    chk("nb dbg_a0 before", o_dbg[1], 32'h0);
    tick();
    idle(1);
    #1;
    chk("nb dbg_a0 after", o_dbg[1], 32'h12345678);
    tick();
    idle(1);
    st[1].iss_en = 1'b1; st[1].iss_rd = 5'd15;
    tick();
    idle(1);
    st[1].wen0 = 1'b1; st[1].waddr0 = 5'd15; st[1].wdata0 = 32'h77;
    st[1].raddr1 = 5'd15;
    #1;
    chk("nb no ready bypass", {31'b0, o_rrdy1[1]}, 32'd0);
    tick();
    idle(1);
    st[1].raddr1 = 5'd15;
    #1;
    chk("nb ready after wb", {31'b0, o_rrdy1[1]}, 32'd1);
    tick();

    // Random traffic on both builds, with occasional reset
    for (int n = 0; n < 400; n++) begin
      rand_in(0);
      rand_in(1);
      rst_a = ($urandom_range(0, 39) == 0);
      rst_b = ($urandom_range(0, 39) == 0);
      tick();
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    idle(0);
    idle(1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
